// File: rtl/icefifo_wr_if.sv
// icefifo_wr_if: byte source handshake plus IDT7201 write-port signals.
// The slave modport is the controller's view; master is the environment's.
interface icefifo_wr_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       fifo_wr;
  logic [7:0] fifo_q;
  logic       fifo_ff;

  modport master (
    output in_data,
    output in_valid,
    output fifo_ff,
    input  in_ready,
    input  fifo_wr,
    input  fifo_q
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  fifo_ff,
    output in_ready,
    output fifo_wr,
    output fifo_q
  );
endinterface

// File: rtl/icefifo_wr.sv
// icefifo_wr: write-side controller for an IDT7201-style asynchronous FIFO.
// Bytes are queued from a valid/ready source and strobed into the FIFO with
// tick-counted setup / strobe / recover phases, throttled by a synchronised -FF.
// Optional feature macro: FIFO_WR_STATS_EN adds the 16-bit wr_count port.
//
// state   | meaning
// IDLE    | waiting for a queued byte and a not-full FIFO
// SETUP   | fifo_q driven, -W high, data setup time
// STROBE  | -W low
// RECOVER | -W high, fifo_q held; -FF from this write settles into ff_s
module icefifo_wr #(
  parameter int DEPTH         = 4,
  parameter int SETUP_TICKS   = 1,
  parameter int STROBE_TICKS  = 4,
  parameter int RECOVER_TICKS = 3
) (
  input  logic              clk,
  input  logic              rst,
  icefifo_wr_if.slave       bus
`ifdef FIFO_WR_STATS_EN
  ,
  output logic [15:0]       wr_count
`endif
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam int RT   = (RECOVER_TICKS < 3) ? 3 : RECOVER_TICKS;
  localparam int TMAX_A = (SETUP_TICKS > STROBE_TICKS) ? SETUP_TICKS : STROBE_TICKS;
  localparam int TMAX   = (TMAX_A > RT) ? TMAX_A : RT;
  localparam int CW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   tick;
  logic            wr_r;
  logic [7:0]      q_r;
  logic            ff_s1;
  logic            ff_s;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CNTW-1:0] count;

  logic            push;
  logic            start;
  logic            tick_done;

  // Ready follows the registered occupancy only, and is held low during reset.
  assign bus.in_ready = rst && (count < FULL_CNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign tick_done    = (tick == '0);

  // A load may start from IDLE or directly at the last RECOVER tick, so
  // back-to-back writes keep the full setup+strobe+recover period and no more.
  assign start = (count != '0) && ff_s &&
                 ((state == IDLE) || ((state == RECOVER) && tick_done));

  assign bus.fifo_wr = wr_r;
  assign bus.fifo_q  = q_r;

  // Two-stage synchroniser for the asynchronous -FF flag; resets to "full".
  always_ff @(posedge clk) begin
    if (!rst) begin
      ff_s1 <= 1'b0;
      ff_s  <= 1'b0;
    end else begin
      ff_s1 <= bus.fifo_ff;
      ff_s  <= ff_s1;
    end
  end

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= bus.in_data;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (start) begin
        head <= head + AW'(1);
      end
      if (push && !start) begin
        count <= count + CNTW'(1);
      end else if (start && !push) begin
        count <= count - CNTW'(1);
      end
    end
  end

  // Write-strobe sequencer with registered -W and data bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tick  <= '0;
      wr_r  <= 1'b1;
      q_r   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_r   <= mem[head];
            tick  <= CW'(SETUP_TICKS - 1);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tick_done) begin
            wr_r  <= 1'b0;
            tick  <= CW'(STROBE_TICKS - 1);
            state <= STROBE;
          end else begin
            tick <= tick - CW'(1);
          end
        end
        STROBE: begin
          if (tick_done) begin
            wr_r  <= 1'b1;
            tick  <= CW'(RT - 1);
            state <= RECOVER;
          end else begin
            tick <= tick - CW'(1);
          end
        end
        RECOVER: begin
          if (tick_done) begin
            if (start) begin
              q_r   <= mem[head];
              tick  <= CW'(SETUP_TICKS - 1);
              state <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick <= tick - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          wr_r  <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_WR_STATS_EN
  // Count completed writes on each -W rising edge; wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_count <= 16'h0000;
    end else if ((state == STROBE) && tick_done) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule
